// File: rtl/lane_scheduler.sv
// Two-lane word striper: alternates accepted words between lane FIFOs and
// pads lane 1 so every burst leaves both lanes with equal word counts.

module lane_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [31:0]             push_data,
    input  logic                    pop,
    output logic [31:0]             head,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = valid ? mem[rd_ptr] : 32'h0;

    // Storage needs no reset: head is masked to zero while the lane is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

module lane_scheduler #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PAD_WORD = 32'h000000BC
) (
    input  logic        clk_2f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [31:0] lane_0,
    output logic [31:0] lane_1,
    output logic        valid_0,
    output logic        valid_1,
    input  logic        pop_0,
    input  logic        pop_1,
    output logic        next_lane,
    output logic [1:0]  state,
    output logic        error
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, STRIPE = 2'd1, PAD = 2'd2} state_t;

    state_t              st;
    logic                nl;
    logic [1:0][CW-1:0]  count;
    logic [1:0][31:0]    head;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic [1:0]          valid;
    logic [31:0]         push_data;
    logic                accept;
    logic                pad_push;

    // Registered counts only: a pop this cycle frees space from the next cycle on.
    assign ready_out = (st != PAD) && (count[nl] < CW'(DEPTH));
    assign accept    = valid_in && ready_out;
    assign pad_push  = (st == PAD) && (count[1] < CW'(DEPTH));
    assign push[0]   = accept && !nl;
    assign push[1]   = (accept && nl) || pad_push;
    assign push_data = pad_push ? PAD_WORD : data_in;
    assign pop       = {pop_1, pop_0};

    generate
        for (genvar l = 0; l < 2; l++) begin : g_lane
            lane_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk       (clk_2f),
                .rst_n     (reset_L),
                .push      (push[l]),
                .push_data (push_data),
                .pop       (pop[l]),
                .head      (head[l]),
                .valid     (valid[l]),
                .count     (count[l])
            );
        end
    endgenerate

    assign lane_0    = head[0];
    assign lane_1    = head[1];
    assign valid_0   = valid[0];
    assign valid_1   = valid[1];
    assign next_lane = nl;
    assign state     = st;

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            st    <= IDLE;
            nl    <= 1'b0;
            error <= 1'b0;
        end else begin
            error <= error | (pop_0 & ~valid[0]) | (pop_1 & ~valid[1]);
            case (st)
                IDLE: begin
                    if (accept) begin
                        st <= STRIPE;
                        nl <= ~nl;
                    end
                end
                STRIPE: begin
                    if (accept)         nl <= ~nl;
                    else if (!valid_in) st <= nl ? PAD : IDLE;
                end
                PAD: begin
                    if (pad_push) begin
                        nl <= 1'b0;
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
